// File: rtl/aftab_trap_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : aftab_trap_pkg                                               |
// | Desc   : CSR addresses, status bit positions, privilege codes and     |
// |          sequencer state encoding for the AFTAB trap sequencer.       |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
package aftab_trap_pkg;

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] c_ADDR_USTATUS = 12'h000;
    localparam logic [11:0] c_ADDR_UTVEC   = 12'h005;
    localparam logic [11:0] c_ADDR_UEPC    = 12'h041;
    localparam logic [11:0] c_ADDR_UCAUSE  = 12'h042;
    localparam logic [11:0] c_ADDR_UTVAL   = 12'h043;

    localparam int c_MIE    = 3;
    localparam int c_MPIE   = 7;
    localparam int c_MPP_HI = 12;
    localparam int c_MPP_LO = 11;
    localparam int c_UIE    = 0;
    localparam int c_UPIE   = 4;

    localparam logic [1:0] c_PRV_USER    = 2'b00;
    localparam logic [1:0] c_PRV_MACHINE = 2'b11;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        T_EPC    = 4'd1,
        T_CAUSE  = 4'd2,
        T_TVAL   = 4'd3,
        T_STATUS = 4'd4,
        T_JUMP   = 4'd5,
        R_STATUS = 4'd6,
        R_JUMP   = 4'd7
    } trapState_t;

endpackage
`default_nettype wire

// File: rtl/aftab_trap_vector_calc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : aftab_trap_vector_calc                                       |
// | Desc   : Handler address from xtvec and cause. Vectored interrupt     |
// |          dispatch only when AFTAB_TRAP_VECTORED_EN is defined.        |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module aftab_trap_vector_calc #(
    parameter int len = 32
) (
    input  logic [len-1:0] xtvec,
    input  logic [len-1:0] cause,
    output logic [len-1:0] handlerAddr
);

    logic [len-1:0] w_base;
    assign w_base = {xtvec[len-1:2], 2'b00};

`ifdef AFTAB_TRAP_VECTORED_EN
    logic [len-1:0] w_offset;
    // cause[len-2:0] << 2 truncated to len bits; the interrupt flag falls off the top
    assign w_offset    = {cause[len-3:0], 2'b00};
    assign handlerAddr = ((xtvec[1:0] == 2'b01) && cause[len-1]) ? (w_base + w_offset) : w_base;
`else
    logic w_unused;
    assign w_unused    = ^{cause, xtvec[1:0]};
    assign handlerAddr = w_base;
`endif

endmodule
`default_nettype wire

// File: rtl/aftab_trap_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : aftab_trap_sequencer                                         |
// | Desc   : Sequences trap entry (xEPC, xCAUSE, xTVAL, xSTATUS, jump)    |
// |          and MRET/URET return. Option: AFTAB_TRAP_VECTORED_EN.        |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module aftab_trap_sequencer #(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           interrupt_raise,
    input  logic           exception_raise,
    input  logic [len-1:0] cause_code,
    input  logic [len-1:0] trap_value,
    input  logic [1:0]     delegation_mode,
    input  logic [1:0]     cur_prv,
    input  logic [len-1:0] out_pc,
    input  logic           mret_req,
    input  logic           uret_req,
    input  logic [len-1:0] mstatus,
    input  logic [len-1:0] ustatus,
    input  logic [len-1:0] mtvec,
    input  logic [len-1:0] utvec,
    input  logic [len-1:0] mepc,
    input  logic [len-1:0] uepc,
    output logic           ld_delegation,
    output logic           csr_wr_en,
    output logic [11:0]    csr_addr,
    output logic [len-1:0] csr_wdata,
    output logic           ld_machine,
    output logic           ld_user,
    output logic           pc_load,
    output logic [len-1:0] pc_new,
    output logic           busy,
    output logic           done
);
    import aftab_trap_pkg::*;

    trapState_t     r_state;
    trapState_t     w_nextState;
    logic [len-1:0] r_cause;
    logic [len-1:0] r_tval;
    logic [len-1:0] r_pc;
    logic [1:0]     r_prv;
    logic           r_modeM;
    logic [1:0]     r_oldMpp;

    logic           w_trap;
    logic           w_modeM;
    logic [len-1:0] w_tvec;
    logic [len-1:0] w_handler;
    logic [len-1:0] w_mTrapStatus;
    logic [len-1:0] w_uTrapStatus;
    logic [len-1:0] w_mRetStatus;
    logic [len-1:0] w_uRetStatus;

    assign w_trap = interrupt_raise | exception_raise;

    // Delegation arrives one cycle after ld_delegation, so T_EPC uses it directly.
    assign w_modeM = (r_state == T_EPC) ? (delegation_mode != c_PRV_USER) : r_modeM;
    assign w_tvec  = r_modeM ? mtvec : utvec;

    aftab_trap_vector_calc #(
        .len (len)
    ) u_vectorCalc (
        .xtvec       (w_tvec),
        .cause       (r_cause),
        .handlerAddr (w_handler)
    );

    always_comb begin
        w_mTrapStatus                    = mstatus;
        w_mTrapStatus[c_MPIE]            = mstatus[c_MIE];
        w_mTrapStatus[c_MIE]             = 1'b0;
        w_mTrapStatus[c_MPP_HI:c_MPP_LO] = r_prv;

        w_uTrapStatus                    = ustatus;
        w_uTrapStatus[c_UPIE]            = ustatus[c_UIE];
        w_uTrapStatus[c_UIE]             = 1'b0;

        w_mRetStatus                     = mstatus;
        w_mRetStatus[c_MIE]              = mstatus[c_MPIE];
        w_mRetStatus[c_MPIE]             = 1'b1;
        w_mRetStatus[c_MPP_HI:c_MPP_LO]  = c_PRV_USER;

        w_uRetStatus                     = ustatus;
        w_uRetStatus[c_UIE]              = ustatus[c_UPIE];
        w_uRetStatus[c_UPIE]             = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cause  <= '0;
            r_tval   <= '0;
            r_pc     <= '0;
            r_prv    <= '0;
            r_modeM  <= 1'b0;
            r_oldMpp <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_trap) begin
                        r_cause <= cause_code;
                        r_tval  <= trap_value;
                        r_pc    <= out_pc;
                        r_prv   <= cur_prv;
                    end else if (mret_req) begin
                        r_modeM <= 1'b1;
                    end else if (uret_req) begin
                        r_modeM <= 1'b0;
                    end
                end
                T_EPC:    r_modeM  <= w_modeM;
                R_STATUS: r_oldMpp <= mstatus[c_MPP_HI:c_MPP_LO];
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_nextState   = r_state;
        ld_delegation = 1'b0;
        csr_wr_en     = 1'b0;
        csr_addr      = '0;
        csr_wdata     = '0;
        ld_machine    = 1'b0;
        ld_user       = 1'b0;
        pc_load       = 1'b0;
        pc_new        = '0;
        done          = 1'b0;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_trap) begin
                    // State is already IDLE during async reset; keep the pulse quiet there.
                    ld_delegation = ~rst;
                    w_nextState   = T_EPC;
                end else if (mret_req || uret_req) begin
                    w_nextState = R_STATUS;
                end
            end
            T_EPC: begin
                csr_wr_en   = 1'b1;
                csr_addr    = w_modeM ? c_ADDR_MEPC : c_ADDR_UEPC;
                csr_wdata   = r_pc;
                w_nextState = T_CAUSE;
            end
            T_CAUSE: begin
                csr_wr_en   = 1'b1;
                csr_addr    = r_modeM ? c_ADDR_MCAUSE : c_ADDR_UCAUSE;
                csr_wdata   = r_cause;
                w_nextState = T_TVAL;
            end
            T_TVAL: begin
                csr_wr_en   = 1'b1;
                csr_addr    = r_modeM ? c_ADDR_MTVAL : c_ADDR_UTVAL;
                csr_wdata   = r_tval;
                w_nextState = T_STATUS;
            end
            T_STATUS: begin
                csr_wr_en   = 1'b1;
                csr_addr    = r_modeM ? c_ADDR_MSTATUS : c_ADDR_USTATUS;
                csr_wdata   = r_modeM ? w_mTrapStatus : w_uTrapStatus;
                w_nextState = T_JUMP;
            end
            T_JUMP: begin
                pc_load     = 1'b1;
                done        = 1'b1;
                pc_new      = w_handler;
                ld_machine  = r_modeM;
                ld_user     = ~r_modeM;
                w_nextState = IDLE;
            end
            R_STATUS: begin
                csr_wr_en   = 1'b1;
                csr_addr    = r_modeM ? c_ADDR_MSTATUS : c_ADDR_USTATUS;
                csr_wdata   = r_modeM ? w_mRetStatus : w_uRetStatus;
                w_nextState = R_JUMP;
            end
            R_JUMP: begin
                pc_load     = 1'b1;
                done        = 1'b1;
                pc_new      = r_modeM ? mepc : uepc;
                if (r_modeM) begin
                    ld_user    = (r_oldMpp == c_PRV_USER);
                    ld_machine = (r_oldMpp != c_PRV_USER);
                end else begin
                    ld_user    = 1'b1;
                end
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aftab_trap_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_aftab_trap_sequencer                                      |
// | Desc   : Scoreboard bench for aftab_trap_sequencer; honours           |
// |          AFTAB_TRAP_VECTORED_EN in its reference model.               |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_aftab_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interrupt_raise, exception_raise, mret_req, uret_req;
    logic [31:0] cause_code, trap_value, out_pc;
    logic [1:0]  delegation_mode, cur_prv;
    logic [31:0] mstatus, ustatus, mtvec, utvec, mepc, uepc;
    logic        ld_delegation, csr_wr_en, ld_machine, ld_user, pc_load, busy, done;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, pc_new;

    aftab_trap_sequencer #(.len(32)) dut (
        .clk(clk), .rst(rst),
        .interrupt_raise(interrupt_raise), .exception_raise(exception_raise),
        .cause_code(cause_code), .trap_value(trap_value),
        .delegation_mode(delegation_mode), .cur_prv(cur_prv), .out_pc(out_pc),
        .mret_req(mret_req), .uret_req(uret_req),
        .mstatus(mstatus), .ustatus(ustatus), .mtvec(mtvec), .utvec(utvec),
        .mepc(mepc), .uepc(uepc),
        .ld_delegation(ld_delegation), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .ld_machine(ld_machine), .ld_user(ld_user),
        .pc_load(pc_load), .pc_new(pc_new), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = ld_delegation pulse, 1 = CSR write, 2 = PC jump
    typedef struct {
        int          cyc;
        int          kind;
        logic [11:0] addr;
        logic [31:0] data;
        logic        ldM;
        logic        ldU;
    } ev_t;

    ev_t q[$];
    int  total     = 0;
    int  bad       = 0;
    int  freeAt    = 0;
    int  acceptCyc = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] handlerOf(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = tvec & 32'hFFFF_FFFC;
`ifdef AFTAB_TRAP_VECTORED_EN
        if ((tvec & 32'h3) == 32'h1 && cause >= 32'h8000_0000)
            return base + 4 * (cause - 32'h8000_0000);
`endif
        return base;
    endfunction

    task automatic push(input int c, input int k, input logic [11:0] a, input logic [31:0] d,
                        input logic m, input logic u);
        ev_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d; e.ldM = m; e.ldU = u;
        q.push_back(e);
    endtask

    // Reference model: called once per cycle after the inputs for that cycle are applied.
    task automatic predict();
        logic [31:0] st;
        logic        m;
        if (cyc < freeAt) return;
        if (interrupt_raise || exception_raise) begin
            m = (delegation_mode != 2'b00);
            push(cyc, 0, 12'h0, 32'h0, 1'b0, 1'b0);
            push(cyc + 1, 1, m ? 12'h341 : 12'h041, out_pc, 1'b0, 1'b0);
            push(cyc + 2, 1, m ? 12'h342 : 12'h042, cause_code, 1'b0, 1'b0);
            push(cyc + 3, 1, m ? 12'h343 : 12'h043, trap_value, 1'b0, 1'b0);
            if (m) begin
                st = mstatus;
                st[7] = mstatus[3];
                st[3] = 1'b0;
                st[12:11] = cur_prv;
            end else begin
                st = ustatus;
                st[4] = ustatus[0];
                st[0] = 1'b0;
            end
            push(cyc + 4, 1, m ? 12'h300 : 12'h000, st, 1'b0, 1'b0);
            push(cyc + 5, 2, 12'h0, handlerOf(m ? mtvec : utvec, cause_code), m, !m);
            acceptCyc = cyc;
            freeAt    = cyc + 6;
        end else if (mret_req) begin
            st = mstatus;
            st[3] = mstatus[7];
            st[7] = 1'b1;
            st[12:11] = 2'b00;
            push(cyc + 1, 1, 12'h300, st, 1'b0, 1'b0);
            push(cyc + 2, 2, 12'h0, mepc, mstatus[12:11] != 2'b00, mstatus[12:11] == 2'b00);
            acceptCyc = cyc;
            freeAt    = cyc + 3;
        end else if (uret_req) begin
            st = ustatus;
            st[0] = ustatus[4];
            st[4] = 1'b1;
            push(cyc + 1, 1, 12'h000, st, 1'b0, 1'b0);
            push(cyc + 2, 2, 12'h0, uepc, 1'b0, 1'b1);
            acceptCyc = cyc;
            freeAt    = cyc + 3;
        end
    endtask

    // Monitor: samples on the falling edge, away from the input/state updates.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (rst) begin
            check("reset_outputs_zero",
                  {ld_delegation, csr_wr_en, ld_machine, ld_user, pc_load, busy, done,
                   |csr_addr, |csr_wdata, |pc_new}, 64'h0);
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            check("done_eq_pc_load", done, pc_load);
            check("busy", busy, (cyc > acceptCyc && cyc < freeAt));
            if (!csr_wr_en) check("wdata_zero_when_idle", csr_wdata, 64'h0);
            if (ld_delegation || csr_wr_en || pc_load) begin
                k = ld_delegation ? 0 : (csr_wr_en ? 1 : 2);
                if (q.size() == 0) begin
                    check("unexpected_output_kind", k, 64'hFF);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_kind", k, e.kind);
                    if (e.kind == 1) begin
                        check("csr_addr", csr_addr, e.addr);
                        check("csr_wdata", csr_wdata, e.data);
                    end else if (e.kind == 2) begin
                        check("pc_new", pc_new, e.data);
                        check("ld_machine", ld_machine, e.ldM);
                        check("ld_user", ld_user, e.ldU);
                    end
                end
            end else begin
                check("stray_priv_load", {ld_machine, ld_user}, 64'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearReq();
        interrupt_raise = 1'b0; exception_raise = 1'b0; mret_req = 1'b0; uret_req = 1'b0;
    endtask

    task automatic setCsrs(input logic [31:0] ms, input logic [31:0] us, input logic [31:0] mt,
                           input logic [31:0] ut, input logic [31:0] me, input logic [31:0] ue);
        mstatus = ms; ustatus = us; mtvec = mt; utvec = ut; mepc = me; uepc = ue;
    endtask

    // Issue the currently applied request, then idle until the model says the block is free.
    task automatic fire();
        predict();
        while (cyc < freeAt) begin
            tick();
            clearReq();
            predict();
        end
    endtask

    initial begin
        clearReq();
        cause_code = '0; trap_value = '0; out_pc = '0; delegation_mode = '0; cur_prv = '0;
        setCsrs('0, '0, '0, '0, '0, '0);
        exception_raise = 1'b1;           // must not leak through while reset is held
        repeat (3) tick();
        rst = 1'b0;
        clearReq();
        freeAt = cyc;

        // Machine exception
        tick();
        setCsrs(32'h8, 32'h0, 32'h800, 32'h0, 32'h0, 32'h0);
        exception_raise = 1'b1; cause_code = 32'h2; trap_value = 32'hDEAD_BEEF;
        out_pc = 32'h100; cur_prv = 2'b11; delegation_mode = 2'b11;
        fire();

        // Vectored machine interrupt
        tick();
        setCsrs(32'h8, 32'h0, 32'h1001, 32'h0, 32'h0, 32'h0);
        interrupt_raise = 1'b1; cause_code = 32'h8000_000B; trap_value = 32'h0;
        out_pc = 32'h200; cur_prv = 2'b00; delegation_mode = 2'b11;
        fire();

        // Delegated user interrupt
        tick();
        setCsrs(32'h0, 32'h1, 32'h0, 32'h400, 32'h0, 32'h0);
        interrupt_raise = 1'b1; cause_code = 32'h8000_0008; trap_value = 32'h55;
        out_pc = 32'h300; cur_prv = 2'b00; delegation_mode = 2'b00;
        fire();

        // MRET back to user
        tick();
        setCsrs(32'h80, 32'h0, 32'h0, 32'h0, 32'h204, 32'h0);
        mret_req = 1'b1;
        fire();

        // URET
        tick();
        setCsrs(32'h0, 32'h10, 32'h0, 32'h0, 32'h0, 32'h318);
        uret_req = 1'b1;
        fire();

        // Simultaneous exception and MRET: the trap wins
        tick();
        setCsrs(32'h1888, 32'h0, 32'h900, 32'h0, 32'h444, 32'h0);
        exception_raise = 1'b1; mret_req = 1'b1; cause_code = 32'h7; trap_value = 32'h1234;
        out_pc = 32'h500; cur_prv = 2'b11; delegation_mode = 2'b11;
        fire();

        // Raise held high across done: back-to-back acceptance
        tick();
        exception_raise = 1'b1; cause_code = 32'h4; delegation_mode = 2'b11;
        predict();
        repeat (13) begin
            tick();
            predict();
        end
        clearReq();
        fire();

        // Reset asserted in T_CAUSE
        tick();
        setCsrs(32'h8, 32'h0, 32'hA00, 32'h0, 32'h0, 32'h0);
        exception_raise = 1'b1; cause_code = 32'h5; trap_value = 32'h99;
        out_pc = 32'h600; cur_prv = 2'b11; delegation_mode = 2'b11;
        predict();
        tick(); clearReq(); predict();
        tick();
        check("pre_reset_cause_addr", csr_addr, 12'h342);
        rst = 1'b1;
        #1;
        check("async_reset_outputs_zero",
              {ld_delegation, csr_wr_en, ld_machine, ld_user, pc_load, busy, done,
               |csr_addr, |csr_wdata, |pc_new}, 64'h0);
        q.delete();
        freeAt    = 0;
        acceptCyc = -10;
        exception_raise = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        freeAt = cyc;
        fire();

        // Randomized traffic, including requests that arrive while busy
        repeat (600) begin
            tick();
            interrupt_raise = ($urandom_range(0, 7) == 0);
            exception_raise = ($urandom_range(0, 7) == 0);
            mret_req        = ($urandom_range(0, 5) == 0);
            uret_req        = ($urandom_range(0, 5) == 0);
            cause_code      = $urandom;
            trap_value      = $urandom;
            out_pc          = $urandom;
            cur_prv         = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            if (cyc >= freeAt) begin
                delegation_mode = 2'($urandom_range(0, 3));
                setCsrs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            end
            predict();
        end
        clearReq();
        fire();
        repeat (3) tick();
        check("scoreboard_drained", q.size(), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
